rx_frame_assembler: RTL and testbench

Parametrised receive framer between the demodulator's `bitout`/`bitsinc` pair and the register field. It hunts a configurable sync word in the recovered bit stream, reads a length word, assembles the payload into `DATA_W`-bit words and buffers them in an internal FIFO. A level interrupt flags frame completion or error. It replaces the fixed 8-bit, single-word assembler and adds framing, buffering and error status.

---
 rtl/rx_frame_assembler.sv | 188 ++++++++++++++++++
 tb/tb_rx_frame_assembler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler
// Receive framer between the demodulator bit recovery and the register field.
// It hunts SYNC_WORD in the recovered bit stream, then reads a length word.
// It assembles that many DATA_W-bit payload words into a first-word
// fall-through FIFO.
//
// Ports:
//   G_CLK_RX   receive clock, all state on rising edge
//   reset      asynchronous, active-low reset
//   enable     0 forces HUNT and clears bit/sync shifters (FIFO and flags kept)
//   bit_in     recovered data bit, qualified by bit_sinc
//   bit_sinc   one-cycle strobe marking a valid bit_in
//   rd_en      pop FIFO head
//   irq_clr    clears interrupt, len_err, overflow (a same-cycle set wins)
//   data_out   FIFO head, zero when empty
//   data_valid FIFO non-empty
//   fifo_count words held in FIFO
//   frame_len  length word of last accepted frame
//   busy       framer is not hunting
//   len_err    sticky: length 0 or above MAX_LEN received
//   overflow   sticky: payload word dropped on full FIFO
//   interrupt  level: frame done or length error
module rx_frame_assembler #(
    parameter int                  DATA_W     = 8,
    parameter int                  SYNC_W     = 16,
    parameter logic [SYNC_W-1:0]   SYNC_WORD  = 16'hA5C3,
    parameter int                  MAX_LEN    = 32,
    parameter int                  FIFO_DEPTH = 16,
    parameter bit                  MSB_FIRST  = 1'b1
) (
    input  logic                            G_CLK_RX,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            bit_in,
    input  logic                            bit_sinc,
    input  logic                            rd_en,
    input  logic                            irq_clr,
    output logic [DATA_W-1:0]               data_out,
    output logic                            data_valid,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [DATA_W-1:0]               frame_len,
    output logic                            busy,
    output logic                            len_err,
    output logic                            overflow,
    output logic                            interrupt
);
    localparam int BC_W  = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_e;

    state_e              state_q, state_d;
    logic [SYNC_W-1:0]   sync_q, sync_d, sync_nxt;
    logic [DATA_W-1:0]   shift_q, shift_d, word_nxt;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   word_cnt_q, word_cnt_d, word_inc;
    logic [DATA_W-1:0]   frame_len_q, frame_len_d;
    logic                irq_q, irq_d, len_err_q, len_err_d, ovf_q, ovf_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic                word_done, push, pop, push_ok, full;
    logic                set_irq, set_len_err, set_ovf;

    // Framer: shifters only move on qualified strobes; enable low aborts.
    always_comb begin
        state_d     = state_q;
        sync_d      = sync_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        frame_len_d = frame_len_q;
        push        = 1'b0;
        set_irq     = 1'b0;
        set_len_err = 1'b0;
        sync_nxt    = {sync_q[SYNC_W-2:0], bit_in};
        word_nxt    = MSB_FIRST ? {shift_q[DATA_W-2:0], bit_in}
                                : {bit_in, shift_q[DATA_W-1:1]};
        word_done   = (bit_cnt_q == BC_W'(DATA_W-1));
        word_inc    = word_cnt_q + DATA_W'(1);
        if (!enable) begin
            state_d   = HUNT;
            sync_d    = '0;
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (bit_sinc) begin
            case (state_q)
                HUNT: begin
                    sync_d = sync_nxt;
                    if (sync_nxt == SYNC_WORD) begin
                        state_d   = LEN;
                        bit_cnt_d = '0;
                    end
                end
                LEN: begin
                    shift_d   = word_nxt;
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (word_done) begin
                        bit_cnt_d = '0;
                        if (word_nxt != '0 && word_nxt <= DATA_W'(MAX_LEN)) begin
                            frame_len_d = word_nxt;
                            word_cnt_d  = '0;
                            state_d     = PAYLOAD;
                        end else begin
                            set_len_err = 1'b1;
                            set_irq     = 1'b1;
                            sync_d      = '0;
                            state_d     = HUNT;
                        end
                    end
                end
                PAYLOAD: begin
                    shift_d   = word_nxt;
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (word_done) begin
                        bit_cnt_d  = '0;
                        push       = 1'b1;
                        word_cnt_d = word_inc;
                        if (word_inc == frame_len_q) begin
                            set_irq = 1'b1;
                            sync_d  = '0;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // FIFO: pop on empty is ignored; a pop frees the slot for a same-cycle push.
    always_comb begin
        full    = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop     = rd_en && (cnt_q != '0);
        push_ok = push && (!full || pop);
        set_ovf = push && !push_ok;
        wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PTR_W'(1) : rptr_q;
        cnt_d   = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - CNT_W'(1);
        irq_d     = set_irq     | (irq_q     & ~irq_clr);
        len_err_d = set_len_err | (len_err_q & ~irq_clr);
        ovf_d     = set_ovf     | (ovf_q     & ~irq_clr);
    end

    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            sync_q      <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            frame_len_q <= '0;
            irq_q       <= 1'b0;
            len_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            frame_len_q <= frame_len_d;
            irq_q       <= irq_d;
            len_err_q   <= len_err_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            if (push_ok) mem_q[wptr_q] <= word_nxt;
        end
    end

    assign data_valid = (cnt_q != '0);
    assign data_out   = data_valid ? mem_q[rptr_q] : '0;
    assign fifo_count = cnt_q;
    assign frame_len  = frame_len_q;
    assign busy       = (state_q != HUNT);
    assign len_err    = len_err_q;
    assign overflow   = ovf_q;
    assign interrupt  = irq_q;
endmodule

// File: tb/tb_rx_frame_assembler.sv
module tb_rx_frame_assembler;
    logic       clk = 1'b0;
    logic       reset, enable, bit_in, bit_sinc, rd_en, irq_clr;
    logic [7:0] data_out, frame_len, data_out_l, frame_len_l;
    logic [4:0] fifo_count, fifo_count_l;
    logic       data_valid, busy, len_err, overflow, interrupt;
    logic       data_valid_l, busy_l, len_err_l, overflow_l, interrupt_l;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    rx_frame_assembler dut (
        .G_CLK_RX(clk), .reset(reset), .enable(enable), .bit_in(bit_in),
        .bit_sinc(bit_sinc), .rd_en(rd_en), .irq_clr(irq_clr),
        .data_out(data_out), .data_valid(data_valid), .fifo_count(fifo_count),
        .frame_len(frame_len), .busy(busy), .len_err(len_err),
        .overflow(overflow), .interrupt(interrupt));

    rx_frame_assembler #(.MSB_FIRST(1'b0)) dut_l (
        .G_CLK_RX(clk), .reset(reset), .enable(enable), .bit_in(bit_in),
        .bit_sinc(bit_sinc), .rd_en(rd_en), .irq_clr(irq_clr),
        .data_out(data_out_l), .data_valid(data_valid_l), .fifo_count(fifo_count_l),
        .frame_len(frame_len_l), .busy(busy_l), .len_err(len_err_l),
        .overflow(overflow_l), .interrupt(interrupt_l));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit, optionally preceded by an idle cycle.
    task automatic send_bit(input logic b);
        repeat ($urandom_range(0, 1)) tick();
        bit_in   = b;
        bit_sinc = 1'b1;
        tick();
        bit_sinc = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_w16(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_vld"}, data_valid, 1);
            chk(tag, data_out, e);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_dvld"}, data_valid, 0);
        chk({tag, "_cnt"}, fifo_count, 0);
        chk({tag, "_flen"}, frame_len, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_lerr"}, len_err, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_irq"}, interrupt, 0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; bit_in = 1'b0; bit_sinc = 1'b0;
        rd_en = 1'b0; irq_clr = 1'b0;
        repeat (3) tick();
        chk_zero("rst");
        reset = 1'b1;
        tick();

        // Basic frame: A5C3, len 3, 11 22 33.
        send_w16(16'hA5C3);
        chk("t1_busy_sync", busy, 1);
        send_byte(8'h03);
        chk("t1_flen", frame_len, 3);
        send_byte(8'h11); sb.push_back(8'h11);
        chk("t1_cnt1", fifo_count, 1);
        send_byte(8'h22); sb.push_back(8'h22);
        chk("t1_irq_early", interrupt, 0);
        send_byte(8'h33); sb.push_back(8'h33);
        chk("t1_irq", interrupt, 1);
        chk("t1_cnt3", fifo_count, 3);
        chk("t1_busy_done", busy, 0);
        for (int i = 0; i < 3; i++) pop_chk("t1_pop");
        chk("t1_irq_held", interrupt, 1);
        chk("t1_empty", data_valid, 0);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("t1_underflow", fifo_count, 0);
        clear_irq();
        chk("t1_irq_clr", interrupt, 0);

        // Bad lengths: 0, then 0x21.
        send_w16(16'hA5C3);
        send_byte(8'h00);
        chk("t2_lerr0", len_err, 1);
        chk("t2_irq0", interrupt, 1);
        chk("t2_busy0", busy, 0);
        clear_irq();
        chk("t2_lerr_clr", len_err, 0);
        send_w16(16'hA5C3);
        send_byte(8'h21);
        chk("t2_lerr21", len_err, 1);
        chk("t2_irq21", interrupt, 1);
        chk("t2_busy21", busy, 0);
        chk("t2_empty", data_valid, 0);
        chk("t2_flen_kept", frame_len, 3);
        clear_irq();

        // Overflow: 20 words into a 16-deep FIFO.
        send_w16(16'hA5C3);
        send_byte(8'd20);
        for (int i = 0; i < 20; i++) begin
            send_byte(8'h40 + 8'(i));
            if (i < 16) sb.push_back(8'h40 + 8'(i));
        end
        chk("t3_cnt", fifo_count, 16);
        chk("t3_ovf", overflow, 1);
        chk("t3_irq", interrupt, 1);
        for (int i = 0; i < 16; i++) pop_chk("t3_pop");
        clear_irq();
        chk("t3_ovf_clr", overflow, 0);

        // Near-miss sync must not lock; exact pattern after noise must.
        send_w16(16'hA5C2);
        chk("t4_nolock", busy, 0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        chk("t4_nolock2", busy, 0);
        send_w16(16'hA5C3);
        chk("t4_lock", busy, 1);
        send_byte(8'h01);
        send_byte(8'h5A); sb.push_back(8'h5A);
        pop_chk("t4_pop");
        clear_irq();

        // Enable dropped mid-payload, then a clean frame.
        send_w16(16'hA5C3);
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_bit(1);
        enable = 1'b0;
        tick(); tick();
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_irq", interrupt, 0);
        chk("t5_abort_vld", data_valid, 0);
        enable = 1'b1;
        tick();
        send_w16(16'hA5C3);
        send_byte(8'h02);
        send_byte(8'hAB); sb.push_back(8'hAB);
        send_byte(8'hCD); sb.push_back(8'hCD);
        chk("t5_irq", interrupt, 1);
        chk("t5_cnt", fifo_count, 2);
        chk("t5_lerr", len_err, 0);
        pop_chk("t5_pop");
        pop_chk("t5_pop");
        clear_irq();

        // LSB-first instance: raw bits 1,0,0,0,0,0,0,0 mean 01h.
        reset = 1'b0; tick(); reset = 1'b1; tick();
        send_w16(16'hA5C3);
        send_byte(8'h80);
        chk("t6_l_flen", frame_len_l, 1);
        chk("t6_m_lerr", len_err, 1);
        send_byte(8'h80);
        chk("t6_l_vld", data_valid_l, 1);
        chk("t6_l_dout", data_out_l, 8'h01);
        chk("t6_l_irq", interrupt_l, 1);
        chk("t6_m_vld", data_valid, 0);

        // Reset mid-payload with 5 words buffered.
        reset = 1'b0; tick(); reset = 1'b1; tick();
        send_w16(16'hA5C3);
        send_byte(8'h08);
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
        chk("t7_cnt5", fifo_count, 5);
        chk("t7_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk_zero("t7_rst");
        tick();
        reset = 1'b1;
        tick();

        // irq_clr coincident with frame done: the set wins.
        send_w16(16'hA5C3);
        send_byte(8'h01);
        for (int i = 7; i >= 1; i--) send_bit(i[0]);
        irq_clr = 1'b1;
        send_bit(1'b0);
        irq_clr = 1'b0;
        sb.push_back(8'b1010_1010);
        chk("t8_irq_set_wins", interrupt, 1);
        pop_chk("t8_pop");
        clear_irq();
        chk("t8_irq_clr", interrupt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
